// File: rtl/seq_pkg.sv
// Shared types and constants for the operand sequencer: FSM states, the default
// 8-entry vector table and, when SEQ_LFSR_EN is defined, the LFSR constants.
package seq_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_OFFER = 2'd1,
      S_HELD  = 2'd2
   } state_t;

   localparam logic [7:0] TBL_A  [8] = '{8'd5,  8'd10, 8'd15, 8'd55, 8'd6,  8'd8, 8'd0,  8'd14};
   localparam logic [7:0] TBL_B  [8] = '{8'd20, 8'd2,  8'd11, 8'd20, 8'd22, 8'd1, 8'd12, 8'd98};
   localparam logic [7:0] TBL_OP [8] = '{8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd6, 8'd7,  8'd8};

`ifdef SEQ_LFSR_EN
   localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
   // Right-shifting Galois form of taps 32,22,2,1.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

   function automatic logic [31:0] bit_rev(input logic [31:0] s);
      logic [31:0] r;
      for (int k = 0; k < 32; k++) r[k] = s[31-k];
      return r;
   endfunction
`endif

endpackage

// File: rtl/btn_debounce.sv
// Raw button to one-cycle step pulse: 2-FF synchroniser, stability counter,
// rising-edge detect on the accepted level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic step_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter restarts whenever the synchronised level agrees with the accepted one,
   // so any glitch shorter than DEBOUNCE_CYCLES is discarded.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
         else                                       cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         cnt_q    <= cnt_d;
      end
   end

   assign step_o = stable_q & ~prev_q;

endmodule

// File: rtl/operand_sequencer.sv
// Steps through a DEPTH-entry operand table on debounced button presses and offers
// each vector over valid/ready. Optional random mode: define SEQ_LFSR_EN.
module operand_sequencer
   import seq_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int OP_W            = 5,
   parameter int DEPTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
`ifdef SEQ_LFSR_EN
   input  logic                     rand_mode,
`endif
   input  logic                     btn_fwd,
   input  logic                     btn_back,
   input  logic                     ready,
   output logic [WIDTH-1:0]         A,
   output logic [WIDTH-1:0]         B,
   output logic [OP_W-1:0]          op,
   output logic                     valid,
   output logic [$clog2(DEPTH)-1:0] index,
   output logic                     overrun
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [OP_W-1:0]  op;
   } entry_t;

   function automatic entry_t rom(input logic [IDX_W-1:0] idx);
      entry_t      r;
      int unsigned i;
      i = 32'(idx);
      if (i < 32'd8) begin
         r.a  = WIDTH'(TBL_A[i[2:0]]);
         r.b  = WIDTH'(TBL_B[i[2:0]]);
         r.op = OP_W'(TBL_OP[i[2:0]]);
      end else begin
         r.a  = WIDTH'(i);
         r.b  = WIDTH'(2 * i);
         r.op = OP_W'((i % 8) + 1);
      end
      return r;
   endfunction

   logic             fwd_step, back_step;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [IDX_W-1:0] idx_q, idx_d, nidx;
   logic             ovr_q, ovr_d;
   logic             fwd, bk, step, load;
   entry_t           e;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fwd (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_fwd), .step_o(fwd_step)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_back), .step_o(back_step)
   );

`ifdef SEQ_LFSR_EN
   logic [31:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (state_q == S_OFFER && ready) lfsr_d = lfsr_step(lfsr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end
`endif

   // Simultaneous presses cancel; wrap-around falls out of the power-of-two index.
   always_comb begin
      fwd  = fwd_step & ~back_step;
      bk   = back_step & ~fwd_step;
      step = fwd | bk;

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      idx_d   = idx_q;
      ovr_d   = ovr_q;
      load    = 1'b0;
      nidx    = idx_q;
      e       = '0;

      case (state_q)
         S_EMPTY: begin
            if (step) begin
               state_d = S_OFFER;
               load    = 1'b1;
               nidx    = '0;
            end
         end
         S_OFFER: begin
            if (step)  ovr_d   = 1'b1;
            if (ready) state_d = S_HELD;
         end
         S_HELD: begin
            if (step) begin
               state_d = S_OFFER;
               load    = 1'b1;
               nidx    = fwd ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
            end
         end
         default: state_d = S_EMPTY;
      endcase

      if (load) begin
         e     = rom(nidx);
         a_d   = e.a;
         b_d   = e.b;
         op_d  = e.op;
         idx_d = nidx;
`ifdef SEQ_LFSR_EN
         if (rand_mode) begin
            a_d   = WIDTH'(lfsr_q);
            b_d   = WIDTH'(bit_rev(lfsr_q));
            op_d  = OP_W'(lfsr_q[2:0]) + OP_W'(1);
            idx_d = idx_q;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         idx_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         ovr_q   <= ovr_d;
      end
   end

   assign A       = a_q;
   assign B       = b_q;
   assign op      = op_q;
   assign index   = idx_q;
   assign valid   = (state_q == S_OFFER);
   assign overrun = ovr_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: stimulus pushes expected vectors, a
// monitor pops and checks each new offer.
module tb_operand_sequencer;

   localparam int WIDTH = 32;
   localparam int OP_W  = 5;
   localparam int DEPTH = 8;
   localparam int DEB   = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             btn_fwd = 1'b0;
   logic             btn_back = 1'b0;
   logic             ready = 1'b0;
   logic [WIDTH-1:0] A, B;
   logic [OP_W-1:0]  op;
   logic             valid;
   logic [2:0]       index;
   logic             overrun;

   operand_sequencer #(
      .WIDTH(WIDTH), .OP_W(OP_W), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_fwd(btn_fwd), .btn_back(btn_back),
      .ready(ready), .A(A), .B(B), .op(op), .valid(valid), .index(index),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  op;
      logic [2:0]  idx;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   bit   seen  = 0;

   // Hand-written table, independent of the design package.
   int unsigned EA [8] = '{5, 10, 15, 55, 6, 8, 0, 14};
   int unsigned EB [8] = '{20, 2, 11, 20, 22, 1, 12, 98};
   int unsigned EOP[8] = '{1, 2, 3, 4, 5, 6, 7, 8};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push(input int i);
      exp_t e;
      e.a = EA[i]; e.b = EB[i]; e.op = 5'(EOP[i]); e.idx = 3'(i);
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!valid) seen = 0;
      else if (!seen) begin
         seen = 1;
         if (sb.size() == 0) chk("unexpected_offer", 1, 0);
         else begin
            e = sb.pop_front();
            chk("offer_A", A, e.a);
            chk("offer_B", B, e.b);
            chk("offer_op", op, e.op);
            chk("offer_index", index, e.idx);
         end
      end
   end

   task automatic press(input bit f, input bit b, input int len);
      @(posedge clk); #1;
      btn_fwd = f; btn_back = b;
      repeat (len) @(posedge clk);
      #1;
      btn_fwd = 0; btn_back = 0;
      repeat (12) @(posedge clk);
   endtask

   task automatic wait_valid();
      int n = 0;
      @(negedge clk);
      while (!valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("wait_valid", valid, 1);
   endtask

   task automatic accept();
      wait_valid();
      ready = 1;
      @(posedge clk); #1;
      ready = 0;
      @(negedge clk);
      chk("valid_after_accept", valid, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_op", op, 0);
      chk("rst_valid", valid, 0);
      chk("rst_index", index, 0);
      chk("rst_overrun", overrun, 0);
      rst_n = 1;

      // Long held press: exactly one step, entry 0.
      push(0);
      press(1, 0, 20);
      accept();

      // Forward through the whole table with wrap to 0.
      for (int i = 1; i <= 8; i++) begin
         push(i % 8);
         press(1, 0, 8);
         accept();
      end

      // Back from 0 wraps to 7, then forward returns to 0.
      push(7);
      press(0, 1, 8);
      accept();
      push(0);
      press(1, 0, 8);
      accept();

      // Glitch shorter than the debounce window.
      press(1, 0, 3);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("glitch_valid", valid, 0);
      chk("glitch_index", index, 0);

      // Simultaneous presses cancel.
      press(1, 1, 10);
      @(negedge clk);
      chk("both_valid", valid, 0);
      chk("both_index", index, 0);
      chk("both_overrun", overrun, 0);

      // Step while an offer is pending is dropped and flagged.
      push(1);
      press(1, 0, 8);
      wait_valid();
      press(1, 0, 8);
      @(negedge clk);
      chk("ovr_flag", overrun, 1);
      chk("ovr_valid", valid, 1);
      chk("ovr_A", A, 10);
      chk("ovr_index", index, 1);
      accept();
      chk("ovr_sticky", overrun, 1);
      push(2);
      press(1, 0, 8);
      accept();
      chk("ovr_sticky2", overrun, 1);

      // Reset in the middle of an offer.
      push(3);
      press(1, 0, 8);
      wait_valid();
      #2 rst_n = 0;
      #1;
      chk("arst_valid", valid, 0);
      chk("arst_A", A, 0);
      chk("arst_B", B, 0);
      chk("arst_op", op, 0);
      chk("arst_index", index, 0);
      chk("arst_overrun", overrun, 0);
      @(negedge clk);
      rst_n = 1;
      push(0);
      press(1, 0, 8);
      accept();

      repeat (5) @(posedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
